// File: rtl/multicycle_control_if.sv
// Memory handshake bundle between the multi-cycle control unit and the
// instruction / data memories. The control unit is the master: it raises
// the requests and the write qualifier, the memories answer with acks.
interface multicycle_control_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_ack;
  logic dmem_we;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output dmem_ack
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle FSM control unit for the reduced RISC-V core.
// Sequences FETCH/DECODE/EXEC/MEM/WB per instruction, drives the datapath
// strobes, runs the imem/dmem handshakes, times out stalled data accesses
// and parks in a sticky TRAP state until reset.
// Optional feature macro: BRANCH_EXT_EN (adds BLT/BGE using the lt flag).
module multicycle_control #(
  parameter int ALU_CTRL_W  = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_control_if.master  mem_bus,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  eq,
  input  logic                  lt,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  alu_src,
  output logic [1:0]            imm_src,
  output logic [1:0]            result_src,
  output logic                  pc_write,
  output logic                  pc_src,
  output logic                  trap,
  output logic [1:0]            trap_cause
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Counter only has to reach MEM_TIMEOUT-1; keep at least one bit so a
  // disabled timeout still elaborates cleanly.
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT =
    CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             trap_reg, trap_next;
  logic [1:0]       cause_reg, cause_next;

  logic             fetch_req, data_req, data_we;
  logic             legal, branch_f3_ok, branch_taken, timeout_hit;
  logic [2:0]       alu_code;
  logic             is_store, is_load;

  assign mem_bus.imem_req = fetch_req;
  assign mem_bus.dmem_req = data_req;
  assign mem_bus.dmem_we  = data_we;

  assign is_store = (opcode == OPC_STORE);
  assign is_load  = (opcode == OPC_LOAD);

  // Zero MEM_TIMEOUT means a data access may stall forever.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_reg == CNT_LIMIT);

`ifdef BRANCH_EXT_EN
  // Branch condition from the ALU flags, BEQ/BNE/BLT/BGE.
  always_comb begin
    branch_f3_ok = 1'b0;
    branch_taken = 1'b0;
    case (funct3)
      3'b000: begin branch_f3_ok = 1'b1; branch_taken = eq;  end
      3'b001: begin branch_f3_ok = 1'b1; branch_taken = !eq; end
      3'b100: begin branch_f3_ok = 1'b1; branch_taken = lt;  end
      3'b101: begin branch_f3_ok = 1'b1; branch_taken = !lt; end
      default: ;
    endcase
  end

  logic unused_inputs;
  assign unused_inputs = &{1'b0, funct7[6], funct7[4:0]};
`else
  // Branch condition from the ALU flags, BEQ/BNE only.
  always_comb begin
    branch_f3_ok = 1'b0;
    branch_taken = 1'b0;
    case (funct3)
      3'b000: begin branch_f3_ok = 1'b1; branch_taken = eq;  end
      3'b001: begin branch_f3_ok = 1'b1; branch_taken = !eq; end
      default: ;
    endcase
  end

  // lt only matters for the extended branches.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, funct7[6], funct7[4:0], lt};
`endif

  // Decode legality of the instruction currently in the IR.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OPC_OP, OPC_OPIMM, OPC_JAL: legal = 1'b1;
      OPC_LOAD, OPC_STORE:        legal = (funct3 == 3'b010);
      OPC_BRANCH:                 legal = branch_f3_ok;
      default:                    legal = 1'b0;
    endcase
  end

  // ALU operation for OP / OP-IMM; only register-register OP can select SUB.
  always_comb begin
    alu_code = 3'd0;
    case (funct3)
      3'b000: alu_code = ((opcode == OPC_OP) && funct7[5]) ? 3'd1 : 3'd0;
      3'b111: alu_code = 3'd2;
      3'b110: alu_code = 3'd3;
      3'b100: alu_code = 3'd4;
      3'b010: alu_code = 3'd5;
      3'b001: alu_code = 3'd6;
      3'b101: alu_code = 3'd7;
      default: alu_code = 3'd0;
    endcase
  end

  // State, wait counter and sticky trap registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_FETCH;
      wait_cnt_reg <= '0;
      trap_reg     <= 1'b0;
      cause_reg    <= 2'b00;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      trap_reg     <= trap_next;
      cause_reg    <= cause_next;
    end
  end

  // Next-state logic; acks are only honoured in the state that waits on them.
  always_comb begin
    state_next    = state_reg;
    trap_next     = trap_reg;
    cause_next    = cause_reg;
    // Cleared everywhere outside MEM, so every MEM entry starts from zero.
    wait_cnt_next = (state_reg == S_MEM) ? wait_cnt_reg + 1'b1 : '0;
    case (state_reg)
      S_FETCH: begin
        if (mem_bus.imem_ack) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (legal) begin
          state_next = S_EXEC;
        end else begin
          state_next = S_TRAP;
          trap_next  = 1'b1;
          cause_next = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        case (opcode)
          OPC_LOAD, OPC_STORE:  state_next = S_MEM;
          OPC_OP, OPC_OPIMM:    state_next = S_WB;
          default:              state_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        // An ack on the limit cycle still completes the access.
        if (mem_bus.dmem_ack) begin
          state_next = is_store ? S_FETCH : S_WB;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          trap_next  = 1'b1;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_WB:    state_next = S_FETCH;
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

  // Datapath strobes; everything is held low while reset is asserted.
  always_comb begin
    fetch_req  = 1'b0;
    ir_write   = 1'b0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    reg_write  = 1'b0;
    alu_ctrl   = '0;
    alu_src    = 1'b0;
    imm_src    = 2'd0;
    result_src = 2'd0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    trap       = rst_n & trap_reg;
    trap_cause = rst_n ? cause_reg : 2'b00;
    if (rst_n) begin
      case (state_reg)
        S_FETCH: begin
          fetch_req = 1'b1;
          ir_write  = mem_bus.imem_ack;
        end
        S_EXEC: begin
          case (opcode)
            OPC_OP: begin
              alu_ctrl = ALU_CTRL_W'(alu_code);
            end
            OPC_OPIMM: begin
              alu_ctrl = ALU_CTRL_W'(alu_code);
              alu_src  = 1'b1;
            end
            OPC_LOAD, OPC_STORE: begin
              alu_src = 1'b1;
              imm_src = is_store ? 2'd1 : 2'd0;
            end
            OPC_BRANCH: begin
              alu_ctrl = ALU_CTRL_W'(3'd1);
              imm_src  = 2'd2;
              pc_write = 1'b1;
              pc_src   = branch_taken;
            end
            OPC_JAL: begin
              imm_src    = 2'd3;
              reg_write  = 1'b1;
              result_src = 2'd2;
              pc_write   = 1'b1;
              pc_src     = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          data_req = 1'b1;
          data_we  = is_store;
          pc_write = is_store & mem_bus.dmem_ack;
        end
        S_WB: begin
          reg_write  = 1'b1;
          result_src = is_load ? 2'd1 : 2'd0;
          pc_write   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (default parameters).
// Strobes are packed into strb = {imem_req, ir_write, dmem_req, dmem_we,
// reg_write, alu_src, pc_write, pc_src, trap} for compact comparisons.
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       eq = 1'b0;
  logic       lt = 1'b0;
  logic       ir_write, reg_write, alu_src, pc_write, pc_src, trap;
  logic [2:0] alu_ctrl;
  logic [1:0] imm_src, result_src, trap_cause;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_bus    (bus.master),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .eq         (eq),
    .lt         (lt),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .alu_ctrl   (alu_ctrl),
    .alu_src    (alu_src),
    .imm_src    (imm_src),
    .result_src (result_src),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

  wire [8:0] strb = {bus.imem_req, ir_write, bus.dmem_req, bus.dmem_we,
                     reg_write, alu_src, pc_write, pc_src, trap};

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    eq = 1'b0;
    lt = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
  endtask

  // From FETCH: ack at once, pass DECODE, return positioned in the next state.
  task automatic fetch_decode();
    bus.imem_ack = 1'b1;
    cyc();
    bus.imem_ack = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    #1;
    if (strb !== 9'b0) begin $display("FAIL reset_strb got=%b exp=%b", strb, 9'b0); errors++; end checks++;
    if (trap_cause !== 2'b00) begin $display("FAIL reset_cause got=%b exp=00", trap_cause); errors++; end checks++;
    cyc();
    if (strb !== 9'b0) begin $display("FAIL reset_hold got=%b exp=%b", strb, 9'b0); errors++; end checks++;
    rst_n = 1'b1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    #1;
    exp = 9'b100000000;
    if (strb !== exp) begin $display("FAIL reset_release got=%b exp=%b", strb, exp); errors++; end checks++;
    $display("txn reset done");
  endtask

  task automatic test_addi();
    do_reset();
    set_instr(7'b0010011, 3'b000, 7'b0100000);
    #1;
    exp = 9'b100000000;
    if (strb !== exp) begin $display("FAIL addi_fetch_wait got=%b exp=%b", strb, exp); errors++; end checks++;
    cyc();
    bus.imem_ack = 1'b1;
    #1;
    exp = 9'b110000000;
    if (strb !== exp) begin $display("FAIL addi_fetch_ack got=%b exp=%b", strb, exp); errors++; end checks++;
    cyc();
    bus.imem_ack = 1'b0;
    #1;
    if (strb !== 9'b0) begin $display("FAIL addi_decode got=%b exp=%b", strb, 9'b0); errors++; end checks++;
    cyc();
    exp = 9'b000001000;
    if (strb !== exp) begin $display("FAIL addi_exec got=%b exp=%b", strb, exp); errors++; end checks++;
    if (alu_ctrl !== 3'd0 || imm_src !== 2'd0) begin $display("FAIL addi_exec_ctrl got=%0d/%0d exp=0/0", alu_ctrl, imm_src); errors++; end checks++;
    cyc();
    exp = 9'b000010100;
    if (strb !== exp) begin $display("FAIL addi_wb got=%b exp=%b", strb, exp); errors++; end checks++;
    if (result_src !== 2'd0 || alu_ctrl !== 3'd0) begin $display("FAIL addi_wb_ctrl got=%0d/%0d exp=0/0", result_src, alu_ctrl); errors++; end checks++;
    cyc();
    exp = 9'b100000000;
    if (strb !== exp) begin $display("FAIL addi_refetch got=%b exp=%b", strb, exp); errors++; end checks++;
    $display("txn ADDI done");
  endtask

  task automatic test_sub();
    do_reset();
    set_instr(7'b0110011, 3'b000, 7'b0100000);
    fetch_decode();
    if (strb !== 9'b0 || alu_ctrl !== 3'd1) begin $display("FAIL sub_exec got=%b/%0d exp=%b/1", strb, alu_ctrl, 9'b0); errors++; end checks++;
    cyc();
    exp = 9'b000010100;
    if (strb !== exp) begin $display("FAIL sub_wb got=%b exp=%b", strb, exp); errors++; end checks++;
    cyc();
    exp = 9'b100000000;
    if (strb !== exp) begin $display("FAIL sub_refetch got=%b exp=%b", strb, exp); errors++; end checks++;
    $display("txn SUB done");
  endtask

  task automatic test_alu_map();
    logic [2:0] f3_tab [7]  = '{3'b000, 3'b111, 3'b110, 3'b100, 3'b010, 3'b001, 3'b101};
    logic [2:0] ctl_tab [7] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_instr(7'b0110011, f3_tab[i], 7'b0000000);
      fetch_decode();
      if (alu_ctrl !== ctl_tab[i] || alu_src !== 1'b0) begin
        $display("FAIL alu_map f3=%b got=%0d/%b exp=%0d/0", f3_tab[i], alu_ctrl, alu_src, ctl_tab[i]); errors++;
      end
      checks++;
      cyc();
      cyc();
      $display("txn OP f3=%b alu_ctrl=%0d", f3_tab[i], alu_ctrl);
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3_tab [4]  = '{3'b001, 3'b001, 3'b000, 3'b000};
    logic       eq_tab [4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       tk_tab [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_instr(7'b1100011, f3_tab[i], 7'b0000000);
      eq = eq_tab[i];
      fetch_decode();
      exp = {6'b000000, 1'b1, tk_tab[i], 1'b0};
      if (strb !== exp || imm_src !== 2'd2 || alu_ctrl !== 3'd1) begin
        $display("FAIL branch_exec f3=%b eq=%b got=%b/%0d/%0d exp=%b/2/1", f3_tab[i], eq, strb, imm_src, alu_ctrl, exp); errors++;
      end
      checks++;
      cyc();
      exp = 9'b100000000;
      if (strb !== exp) begin $display("FAIL branch_refetch got=%b exp=%b", strb, exp); errors++; end checks++;
      $display("txn BRANCH f3=%b eq=%b pc_src=%b", f3_tab[i], eq_tab[i], tk_tab[i]);
    end
    eq = 1'b0;
  endtask

  task automatic test_jal();
    do_reset();
    set_instr(7'b1101111, 3'b000, 7'b0000000);
    fetch_decode();
    exp = 9'b000010110;
    if (strb !== exp || imm_src !== 2'd3 || result_src !== 2'd2) begin
      $display("FAIL jal_exec got=%b/%0d/%0d exp=%b/3/2", strb, imm_src, result_src, exp); errors++;
    end
    checks++;
    cyc();
    exp = 9'b100000000;
    if (strb !== exp) begin $display("FAIL jal_refetch got=%b exp=%b", strb, exp); errors++; end checks++;
    $display("txn JAL done");
  endtask

  task automatic test_load();
    do_reset();
    set_instr(7'b0000011, 3'b010, 7'b0000000);
    fetch_decode();
    bus.imem_ack = 1'b1;
    #1;
    exp = 9'b000001000;
    if (strb !== exp || imm_src !== 2'd0 || alu_ctrl !== 3'd0) begin
      $display("FAIL lw_exec got=%b/%0d/%0d exp=%b/0/0", strb, imm_src, alu_ctrl, exp); errors++;
    end
    checks++;
    for (int w = 0; w < 4; w++) begin
      cyc();
      bus.dmem_ack = (w == 3);
      #1;
      exp = 9'b001000000;
      if (strb !== exp) begin $display("FAIL lw_mem%0d got=%b exp=%b", w, strb, exp); errors++; end checks++;
    end
    cyc();
    bus.dmem_ack = 1'b0;
    bus.imem_ack = 1'b0;
    #1;
    exp = 9'b000010100;
    if (strb !== exp || result_src !== 2'd1) begin $display("FAIL lw_wb got=%b/%0d exp=%b/1", strb, result_src, exp); errors++; end checks++;
    cyc();
    exp = 9'b100000000;
    if (strb !== exp) begin $display("FAIL lw_refetch got=%b exp=%b", strb, exp); errors++; end checks++;
    $display("txn LW 3 waits done");
  endtask

  task automatic test_store_ack_limit();
    do_reset();
    set_instr(7'b0100011, 3'b010, 7'b0000000);
    fetch_decode();
    exp = 9'b000001000;
    if (strb !== exp || imm_src !== 2'd1) begin $display("FAIL sw_exec got=%b/%0d exp=%b/1", strb, imm_src, exp); errors++; end checks++;
    for (int w = 0; w < 15; w++) begin
      cyc();
      bus.dmem_ack = (w == 14);
      #1;
      exp = (w == 14) ? 9'b001100100 : 9'b001100000;
      if (strb !== exp) begin $display("FAIL sw_limit_mem%0d got=%b exp=%b", w, strb, exp); errors++; end checks++;
    end
    cyc();
    bus.dmem_ack = 1'b0;
    #1;
    exp = 9'b100000000;
    if (strb !== exp || trap_cause !== 2'b00) begin $display("FAIL sw_limit_refetch got=%b/%b exp=%b/00", strb, trap_cause, exp); errors++; end checks++;
    $display("txn SW ack on limit cycle done");
  endtask

  task automatic test_store_timeout();
    do_reset();
    set_instr(7'b0100011, 3'b010, 7'b0000000);
    fetch_decode();
    for (int w = 0; w < 15; w++) begin
      cyc();
      exp = 9'b001100000;
      if (strb !== exp) begin $display("FAIL sw_to_mem%0d got=%b exp=%b", w, strb, exp); errors++; end checks++;
    end
    cyc();
    exp = 9'b000000001;
    if (strb !== exp || trap_cause !== 2'b10) begin $display("FAIL sw_timeout got=%b/%b exp=%b/10", strb, trap_cause, exp); errors++; end checks++;
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    repeat (3) begin
      cyc();
      if (strb !== exp || trap_cause !== 2'b10) begin $display("FAIL trap_sticky got=%b/%b exp=%b/10", strb, trap_cause, exp); errors++; end checks++;
    end
    rst_n = 1'b0;
    #1;
    if (strb !== 9'b0 || trap_cause !== 2'b00) begin $display("FAIL trap_reset got=%b/%b exp=%b/00", strb, trap_cause, 9'b0); errors++; end checks++;
    do_reset();
    $display("txn SW timeout done");
  endtask

  task automatic test_illegal();
    logic [6:0] op_tab [3] = '{7'b0000000, 7'b0000011, 7'b0100011};
    logic [2:0] f3_tab [3] = '{3'b000, 3'b000, 3'b001};
    for (int i = 0; i < 3; i++) begin
      do_reset();
      set_instr(op_tab[i], f3_tab[i], 7'b0000000);
      bus.imem_ack = 1'b1;
      cyc();
      bus.imem_ack = 1'b0;
      if (strb !== 9'b0) begin $display("FAIL illegal_decode op=%b got=%b exp=%b", op_tab[i], strb, 9'b0); errors++; end checks++;
      cyc();
      exp = 9'b000000001;
      if (strb !== exp || trap_cause !== 2'b01) begin $display("FAIL illegal_trap op=%b got=%b/%b exp=%b/01", op_tab[i], strb, trap_cause, exp); errors++; end checks++;
      $display("txn illegal op=%b f3=%b", op_tab[i], f3_tab[i]);
    end
  endtask

  task automatic test_branch_ext();
    do_reset();
    set_instr(7'b1100011, 3'b100, 7'b0000000);
    lt = 1'b1;
    fetch_decode();
`ifdef BRANCH_EXT_EN
    exp = 9'b000000110;
    if (strb !== exp || trap_cause !== 2'b00) begin $display("FAIL blt_taken got=%b/%b exp=%b/00", strb, trap_cause, exp); errors++; end checks++;
`else
    exp = 9'b000000001;
    if (strb !== exp || trap_cause !== 2'b01) begin $display("FAIL blt_illegal got=%b/%b exp=%b/01", strb, trap_cause, exp); errors++; end checks++;
`endif
    lt = 1'b0;
    $display("txn BLT lt=1 done");
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    set_instr(7'b0000011, 3'b010, 7'b0000000);
    fetch_decode();
    cyc();
    exp = 9'b001000000;
    if (strb !== exp) begin $display("FAIL midmem_req got=%b exp=%b", strb, exp); errors++; end checks++;
    rst_n = 1'b0;
    #1;
    if (strb !== 9'b0) begin $display("FAIL midmem_drop got=%b exp=%b", strb, 9'b0); errors++; end checks++;
    cyc();
    rst_n = 1'b1;
    bus.dmem_ack = 1'b1;
    #1;
    exp = 9'b100000000;
    if (strb !== exp) begin $display("FAIL midmem_restart got=%b exp=%b", strb, exp); errors++; end checks++;
    cyc();
    if (strb !== exp) begin $display("FAIL dmem_ack_in_fetch got=%b exp=%b", strb, exp); errors++; end checks++;
    bus.dmem_ack = 1'b0;
    $display("txn reset mid-MEM done");
  endtask

  initial begin
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    test_reset();
    test_addi();
    test_sub();
    test_alu_map();
    test_branch();
    test_jal();
    test_load();
    test_store_ack_limit();
    test_store_timeout();
    test_illegal();
    test_branch_ext();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
